// File: rtl/mul_share_arbiter.sv
// Round-robin arbiter sharing one unsigned A_W x B_W multiplier across NUM_REQ requesters.
// Optional perf counters are built only when MUL_SHARE_ARBITER_PERF_EN is defined.
module mul_share_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2,
  parameter int A_W     = 24,
  parameter int B_W     = 60,
  parameter int P_W     = 83,
  parameter int LATENCY = 2
) (
  input  logic                   ap_clk,
  input  logic                   ap_rst_n,
  input  logic [NUM_REQ-1:0]     req_valid,
  output logic [NUM_REQ-1:0]     req_ready,
  input  logic [NUM_REQ*A_W-1:0] req_a,
  input  logic [NUM_REQ*B_W-1:0] req_b,
  output logic                   res_valid,
  input  logic                   res_ready,
  output logic [ID_W-1:0]        res_id,
  output logic [P_W-1:0]         res_data,
`ifdef MUL_SHARE_ARBITER_PERF_EN
  output logic [31:0]            perf_ops,
  output logic [31:0]            perf_stall,
  input  logic                   perf_clr,
`endif
  output logic                   busy
);

  localparam int M_W = A_W + B_W;

  // Handshake: a request transfers on req_valid[i] && req_ready[i]; a result
  // transfers on res_valid && res_ready. Every stage moves together when adv.
  logic [ID_W-1:0]    rr_ptr_q, rr_ptr_d;
  logic [LATENCY-1:0] vld_q, vld_d;
  logic [ID_W-1:0]    id_q   [LATENCY];
  logic [ID_W-1:0]    id_d   [LATENCY];
  logic [P_W-1:0]     data_q [LATENCY];
  logic [P_W-1:0]     data_d [LATENCY];

  logic            adv;
  logic            found;
  logic            xfer;
  logic [ID_W-1:0] grant;
  logic [A_W-1:0]  a_sel;
  logic [B_W-1:0]  b_sel;
  logic [P_W-1:0]  prod;

  assign res_valid = vld_q[LATENCY-1];
  assign res_id    = id_q[LATENCY-1];
  assign res_data  = data_q[LATENCY-1];
  assign busy      = |vld_q;

  // Descending scan so the lowest offset from rr_ptr wins.
  always_comb begin
    adv       = !vld_q[LATENCY-1] || res_ready;
    found     = 1'b0;
    grant     = '0;
    req_ready = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        grant = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
      end
    end
    if (ap_rst_n && adv && found) begin
      req_ready[grant] = 1'b1;
    end
    xfer = |req_ready;
  end

  always_comb begin
    a_sel = req_a[int'(grant) * A_W +: A_W];
    b_sel = req_b[int'(grant) * B_W +: B_W];
    prod  = P_W'(M_W'(a_sel) * M_W'(b_sel));
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (xfer) begin
      rr_ptr_d = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + ID_W'(1);
    end
  end

  // Bubbles enter stage 0 whenever the pipe advances without a transfer.
  always_comb begin
    vld_d  = vld_q;
    id_d   = id_q;
    data_d = data_q;
    if (adv) begin
      vld_d[0]  = xfer;
      id_d[0]   = grant;
      data_d[0] = prod;
      for (int s = 1; s < LATENCY; s++) begin
        vld_d[s]  = vld_q[s-1];
        id_d[s]   = id_q[s-1];
        data_d[s] = data_q[s-1];
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      rr_ptr_q <= '0;
      vld_q    <= '0;
      for (int s = 0; s < LATENCY; s++) begin
        id_q[s]   <= '0;
        data_q[s] <= '0;
      end
    end else begin
      rr_ptr_q <= rr_ptr_d;
      vld_q    <= vld_d;
      for (int s = 0; s < LATENCY; s++) begin
        id_q[s]   <= id_d[s];
        data_q[s] <= data_d[s];
      end
    end
  end

`ifdef MUL_SHARE_ARBITER_PERF_EN
  logic [31:0] perf_ops_q, perf_ops_d;
  logic [31:0] perf_stall_q, perf_stall_d;

  assign perf_ops   = perf_ops_q;
  assign perf_stall = perf_stall_q;

  // Clear wins over increment; both counters stick at all-ones.
  always_comb begin
    perf_ops_d   = perf_ops_q;
    perf_stall_d = perf_stall_q;
    if (perf_clr) begin
      perf_ops_d   = '0;
      perf_stall_d = '0;
    end else begin
      if (xfer && perf_ops_q != '1) begin
        perf_ops_d = perf_ops_q + 32'd1;
      end
      if (!adv && |req_valid && perf_stall_q != '1) begin
        perf_stall_d = perf_stall_q + 32'd1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      perf_ops_q   <= '0;
      perf_stall_q <= '0;
    end else begin
      perf_ops_q   <= perf_ops_d;
      perf_stall_q <= perf_stall_d;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arbiter.sv
// Scoreboard bench for mul_share_arbiter: behavioural round-robin/latency model plus result queue.
module tb_mul_share_arbiter;

  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;
  localparam int A_W     = 24;
  localparam int B_W     = 60;
  localparam int P_W     = 83;
  localparam int LATENCY = 2;
  localparam int E_W     = ID_W + P_W;

  logic                   ap_clk = 1'b0;
  logic                   ap_rst_n;
  logic [NUM_REQ-1:0]     req_valid;
  logic [NUM_REQ-1:0]     req_ready;
  logic [NUM_REQ*A_W-1:0] req_a;
  logic [NUM_REQ*B_W-1:0] req_b;
  logic                   res_valid;
  logic                   res_ready;
  logic [ID_W-1:0]        res_id;
  logic [P_W-1:0]         res_data;
  logic                   busy;
`ifdef MUL_SHARE_ARBITER_PERF_EN
  logic [31:0]            perf_ops;
  logic [31:0]            perf_stall;
  logic                   perf_clr;
  int                     ops_m;
  int                     stall_m;
`endif

  int          n_vec;
  int          n_err;
  int          rr_m;
  int          age_q[$];
  logic [E_W-1:0] exp_q[$];
  logic        prev_hold;
  logic [ID_W-1:0] prev_id;
  logic [P_W-1:0]  prev_data;

  mul_share_arbiter #(
    .NUM_REQ(NUM_REQ), .ID_W(ID_W), .A_W(A_W), .B_W(B_W), .P_W(P_W), .LATENCY(LATENCY)
  ) dut (
    .ap_clk    (ap_clk),
    .ap_rst_n  (ap_rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_id    (res_id),
    .res_data  (res_data),
`ifdef MUL_SHARE_ARBITER_PERF_EN
    .perf_ops  (perf_ops),
    .perf_stall(perf_stall),
    .perf_clr  (perf_clr),
`endif
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  always #5 ap_clk = ~ap_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- helpers ----------------
  function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    logic [A_W+B_W-1:0] full;
    full = (A_W+B_W)'(a) * (A_W+B_W)'(b);
    return full[P_W-1:0];
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic set_ops(input int i, input logic [A_W-1:0] a, input logic [B_W-1:0] b);
    req_a[i*A_W +: A_W] = a;
    req_b[i*B_W +: B_W] = b;
  endtask

  task automatic rand_ops();
    for (int i = 0; i < NUM_REQ; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        set_ops(i, '1, '1);
      end else begin
        set_ops(i, A_W'($urandom()), B_W'({$urandom(), $urandom()}));
      end
    end
  endtask

  task automatic drive(input logic [NUM_REQ-1:0] v, input logic rdy, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      req_valid = v;
      res_ready = rdy;
      rand_ops();
      step();
    end
  endtask

  task automatic drain();
    int w;
    w = 0;
    req_valid = '0;
    res_ready = 1'b1;
    while (age_q.size() != 0 && w < 50) begin
      step();
      w++;
    end
    chk("drain_timeout", 128'(w >= 50), 128'(0));
  endtask

  // ---------------- reference model + request-side checks ----------------
  always @(negedge ap_clk) begin
    logic exp_v;
    logic adv_m;
    logic [NUM_REQ-1:0] exp_rdy;
    int g;
    int idx;
    if (!ap_rst_n) begin
      age_q.delete();
      exp_q.delete();
      rr_m      = 0;
      prev_hold = 1'b0;
`ifdef MUL_SHARE_ARBITER_PERF_EN
      ops_m   = 0;
      stall_m = 0;
`endif
      chk("rst_req_ready", 128'(req_ready), 128'(0));
      chk("rst_res_valid", 128'(res_valid), 128'(0));
      chk("rst_res_id",    128'(res_id),    128'(0));
      chk("rst_res_data",  128'(res_data),  128'(0));
      chk("rst_busy",      128'(busy),      128'(0));
    end else begin
      exp_v = (age_q.size() > 0) && (age_q[0] == LATENCY);
      chk("res_valid", 128'(res_valid), 128'(exp_v));
      chk("busy", 128'(busy), 128'(age_q.size() != 0));
      if (prev_hold) begin
        chk("hold_id",   128'(res_id),   128'(prev_id));
        chk("hold_data", 128'(res_data), 128'(prev_data));
      end
      adv_m   = !exp_v || res_ready;
      exp_rdy = '0;
      g       = -1;
      if (adv_m) begin
        for (int k = 0; k < NUM_REQ; k++) begin
          idx = (rr_m + k) % NUM_REQ;
          if (g < 0 && req_valid[idx]) g = idx;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      chk("req_ready", 128'(req_ready), 128'(exp_rdy));
`ifdef MUL_SHARE_ARBITER_PERF_EN
      if (perf_clr) begin
        ops_m   = 0;
        stall_m = 0;
      end else begin
        if (g >= 0) ops_m++;
        if (!adv_m && |req_valid) stall_m++;
      end
`endif
      if (adv_m) begin
        if (exp_v) void'(age_q.pop_front());
        foreach (age_q[j]) age_q[j]++;
        if (g >= 0) begin
          age_q.push_back(1);
          exp_q.push_back({ID_W'(g), ref_mul(req_a[g*A_W +: A_W], req_b[g*B_W +: B_W])});
          rr_m = (g + 1) % NUM_REQ;
        end
      end
      prev_hold = res_valid && !res_ready;
      prev_id   = res_id;
      prev_data = res_data;
    end
  end

  // ---------------- result monitor / scoreboard ----------------
  always @(negedge ap_clk) begin
    logic [E_W-1:0] e;
    if (ap_rst_n && res_valid && res_ready) begin
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL res_unexpected: got id %0d data %0h, expected no result", res_id, res_data);
      end else begin
        e = exp_q.pop_front();
        chk("res_id",   128'(res_id),   128'(e[E_W-1:P_W]));
        chk("res_data", 128'(res_data), 128'(e[P_W-1:0]));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    n_vec     = 0;
    n_err     = 0;
    rr_m      = 0;
    prev_hold = 1'b0;
    ap_rst_n  = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    res_ready = 1'b1;
`ifdef MUL_SHARE_ARBITER_PERF_EN
    perf_clr  = 1'b0;
`endif
    repeat (3) step();
    ap_rst_n = 1'b1;
    step();

    // single max-operand request from requester 0
    req_valid = 4'b0001;
    set_ops(0, '1, '1);
    step();
    req_valid = '0;
    drain();

    // all requesters continuously, then a 5-cycle backpressure window
    drive(4'b1111, 1'b1, 12);
    drive(4'b1111, 1'b0, 5);
    drive(4'b1111, 1'b1, 6);
    drain();

    // fairness: move pointer to 3, then only requesters 1 and 3 with 7*6
    drive(4'b0100, 1'b1, 1);
    req_valid = 4'b1010;
    for (int i = 0; i < NUM_REQ; i++) set_ops(i, A_W'(7), B_W'(6));
    repeat (3) step();
    drain();

    // asynchronous reset with entries in flight
    drive(4'b1111, 1'b1, 3);
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("async_res_valid", 128'(res_valid), 128'(0));
    chk("async_req_ready", 128'(req_ready), 128'(0));
    chk("async_busy",      128'(busy),      128'(0));
    step();
    step();
    #1;
    ap_rst_n = 1'b1;
    drive(4'b1111, 1'b1, 4);
    drain();

    // randomized traffic with random backpressure
    for (int c = 0; c < 600; c++) begin
      req_valid = NUM_REQ'($urandom_range(0, (1 << NUM_REQ) - 1));
      res_ready = ($urandom_range(0, 3) != 0);
      rand_ops();
      step();
    end
    drain();
    chk("scoreboard_empty", 128'(exp_q.size()), 128'(0));

`ifdef MUL_SHARE_ARBITER_PERF_EN
    chk("perf_ops",   128'(perf_ops),   128'(ops_m));
    chk("perf_stall", 128'(perf_stall), 128'(stall_m));
    perf_clr = 1'b1;
    step();
    perf_clr = 1'b0;
    chk("perf_ops_clr",   128'(perf_ops),   128'(0));
    chk("perf_stall_clr", 128'(perf_stall), 128'(0));
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
